// File: rtl/mutex_lock_engine.sv
// Lock-acquire engine: runs the mutex write/read-back handshake with fixed backoff on behalf of the CPU.
// Optional feature: define MUTEX_LOCK_IRQ_EN to add a completion interrupt (irq) and STATUS bit3.
module mutex_lock_engine #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter int unsigned MAX_RETRIES    = 255,
  parameter int unsigned BACKOFF_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write,
  input  logic        s_read,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
`ifdef MUTEX_LOCK_IRQ_EN
  ,
  output logic        irq
`endif
);
  typedef enum logic [2:0] {IDLE, ACQ_WR, ACQ_RD, BACKOFF, REL_WR} state_t;

  localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);
  localparam logic [7:0] BO    = 8'(BACKOFF_CYCLES);

  state_t      state_q;
  logic [15:0] value_q;
  logic        held_q, fail_q;
  logic [7:0]  retry_q, retry_d, bo_q;
  logic [31:0] last_q;
  logic        m_cs_q, m_wr_q, m_rd_q;
  logic [31:0] m_wd_q;
  logic        irq_bit;

  logic cpu_wr, acq_go, rel_go, match, give_up;
  assign cpu_wr  = s_chipselect & s_write & (state_q == IDLE);
  assign acq_go  = cpu_wr & (s_address == 2'd0) & (s_writedata[15:0] != 16'h0) & ~held_q;
  assign rel_go  = cpu_wr & (s_address == 2'd1);
  assign match   = (m_readdata == {OWNER_ID, value_q});
  assign retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
  assign give_up = (MAX_R != 8'd0) && (retry_d == MAX_R);

  logic unused_in;
  assign unused_in = ^{s_writedata[31:16], s_read};

  // Mutex strobes are registered: they are loaded on the edge that enters the bus state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      value_q <= 16'h0;
      held_q  <= 1'b0;
      fail_q  <= 1'b0;
      retry_q <= 8'h0;
      bo_q    <= 8'h0;
      last_q  <= 32'h0;
      m_cs_q  <= 1'b0;
      m_wr_q  <= 1'b0;
      m_rd_q  <= 1'b0;
      m_wd_q  <= 32'h0;
    end else begin
      m_cs_q <= 1'b0;
      m_wr_q <= 1'b0;
      m_rd_q <= 1'b0;
      m_wd_q <= 32'h0;
      case (state_q)
        IDLE: begin
          if (acq_go) begin
            value_q <= s_writedata[15:0];
            fail_q  <= 1'b0;
            retry_q <= 8'h0;
            state_q <= ACQ_WR;
            m_cs_q  <= 1'b1;
            m_wr_q  <= 1'b1;
            m_wd_q  <= {OWNER_ID, s_writedata[15:0]};
          end else if (rel_go) begin
            state_q <= REL_WR;
            m_cs_q  <= 1'b1;
            m_wr_q  <= 1'b1;
            m_wd_q  <= {OWNER_ID, 16'h0000};
          end
        end
        ACQ_WR: begin
          state_q <= ACQ_RD;
          m_cs_q  <= 1'b1;
          m_rd_q  <= 1'b1;
        end
        ACQ_RD: begin
          last_q <= m_readdata;
          if (match) begin
            held_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            retry_q <= retry_d;
            if (give_up) begin
              fail_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              bo_q    <= BO;
              state_q <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          bo_q <= bo_q - 8'd1;
          if (bo_q == 8'd1) begin
            state_q <= ACQ_WR;
            m_cs_q  <= 1'b1;
            m_wr_q  <= 1'b1;
            m_wd_q  <= {OWNER_ID, value_q};
          end
        end
        REL_WR: begin
          held_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MUTEX_LOCK_IRQ_EN
  logic irq_q;
  logic acq_done, stat_rd;
  assign acq_done = (state_q == ACQ_RD) & (match | give_up);
  assign stat_rd  = s_chipselect & s_read & (s_address == 2'd2);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               irq_q <= 1'b0;
    else if (acq_done)          irq_q <= 1'b1;
    else if (stat_rd || acq_go) irq_q <= 1'b0;
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign m_address    = 1'b0;
  assign m_chipselect = m_cs_q;
  assign m_write      = m_wr_q;
  assign m_read       = m_rd_q;
  assign m_writedata  = m_wd_q;

  always_comb begin
    s_readdata = 32'h0;
    case (s_address)
      2'd2:    s_readdata = {16'h0, retry_q, 4'h0, irq_bit, fail_q, held_q, state_q != IDLE};
      2'd3:    s_readdata = last_q;
      default: s_readdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_mutex_lock_engine.sv
// Scoreboard bench: stimulus queues expected mutex transactions and CPU read data, a monitor pops and compares.
module tb_mutex_lock_engine;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0, s_write = 1'b0, s_read = 1'b0;
  logic [31:0] s_writedata = 32'h0;
  logic [31:0] s_readdata;
  logic        m_address, m_chipselect, m_write, m_read;
  logic [31:0] m_writedata, m_readdata;
`ifdef MUTEX_LOCK_IRQ_EN
  logic        irq;
`endif

  typedef struct { int c; logic wr; logic rd; logic [31:0] wd; } mtx_t;
  typedef struct { string nm; logic [31:0] v; } rd_t;
  mtx_t mq[$];
  rd_t  rq[$];

  int errors = 0, checks = 0;
  int cyc = 0, rd_cnt = 0, fail_until = 0;
  logic        fin = 1'b0;
  logic [31:0] mtx_q = 32'h0;

  mutex_lock_engine #(.OWNER_ID(16'h0001), .MAX_RETRIES(4), .BACKOFF_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write(s_write), .s_read(s_read),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_readdata(m_readdata)
`ifdef MUTEX_LOCK_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Mutex model: stores the last written word; the first reads up to fail_until see a foreign owner
  assign m_readdata = (rd_cnt < fail_until) ? 32'h00020007 : mtx_q;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && m_write) mtx_q <= m_writedata;
    if (m_chipselect && m_read) rd_cnt <= rd_cnt + 1;
  end

  initial begin : monitor
    mtx_t e;
    rd_t  r;
    forever begin
      @(negedge clk or negedge reset_n);
      if (clk) begin
        #1;
        checks++;
        if ({m_chipselect, m_write, m_read, m_address} !== 4'b0 || m_writedata !== 32'h0 || s_readdata !== 32'h0) begin
          errors++;
          $display("FAIL async_reset cs=%b wr=%b rd=%b wd=%h status=%h, want all 0",
                   m_chipselect, m_write, m_read, m_writedata, s_readdata);
        end
      end else begin
        if (m_chipselect) begin
          checks++;
          if (mq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mutex_txn cyc=%0d wr=%b rd=%b wd=%h", cyc, m_write, m_read, m_writedata);
          end else begin
            e = mq.pop_front();
            if (cyc != e.c || m_write !== e.wr || m_read !== e.rd || m_address !== 1'b0 || m_writedata !== e.wd) begin
              errors++;
              $display("FAIL mutex_txn got cyc=%0d wr=%b rd=%b a=%b wd=%h, want cyc=%0d wr=%b rd=%b a=0 wd=%h",
                       cyc, m_write, m_read, m_address, m_writedata, e.c, e.wr, e.rd, e.wd);
            end
          end
        end else begin
          checks++;
          if (m_write !== 1'b0 || m_read !== 1'b0 || m_address !== 1'b0 || m_writedata !== 32'h0) begin
            errors++;
            $display("FAIL idle_bus cyc=%0d wr=%b rd=%b a=%b wd=%h, want all 0", cyc, m_write, m_read, m_address, m_writedata);
          end
        end
        if (s_chipselect && s_read) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cpu_read cyc=%0d", cyc);
          end else begin
            r = rq.pop_front();
            if (s_readdata !== r.v) begin
              errors++;
              $display("FAIL %s cyc=%0d got %h want %h", r.nm, cyc, s_readdata, r.v);
            end
          end
        end
        if (fin) begin
          checks++;
          if (mq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got mutex=%0d reads=%0d want 0 0", mq.size(), rq.size());
          end
        end
      end
    end
  end

  task automatic drive(input logic cs, input logic wr, input logic rd, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_chipselect = cs; s_write = wr; s_read = rd; s_address = a; s_writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  // Returns the cycle in which a resulting bus state would start
  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d, output int c);
    drive(1'b1, 1'b1, 1'b0, a, d);
    c = cyc + 1;
  endtask

  task automatic cpu_rd(input string nm, input logic [1:0] a, input logic [31:0] v);
    rq.push_back('{nm, v});
    drive(1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic exp_attempt(input int c, input logic [31:0] wd);
    mq.push_back('{c, 1'b1, 1'b0, wd});
    mq.push_back('{c + 1, 1'b0, 1'b1, 32'h0});
  endtask

  initial begin : stim
    int c, unused_c;
    idle(2);
    reset_n = 1'b1;
    cpu_rd("reset_status", 2'd2, 32'h0);
    cpu_rd("reset_last", 2'd3, 32'h0);

    // free mutex, uncontended acquire
    fail_until = rd_cnt;
    cpu_wr(2'd0, 32'h0000_0005, c);
    exp_attempt(c, 32'h00010005);
    cpu_rd("acq_status_c1", 2'd2, 32'h1);
    cpu_rd("acq_status_c2", 2'd2, 32'h1);
    cpu_rd("acq_status_c3", 2'd2, 32'h2);
    cpu_rd("acq_last", 2'd3, 32'h00010005);

    // release
    cpu_wr(2'd1, 32'hDEAD_BEEF, c);
    mq.push_back('{c, 1'b1, 1'b0, 32'h00010000});
    cpu_rd("rel_status_busy", 2'd2, 32'h3);
    cpu_rd("rel_status_done", 2'd2, 32'h0);

    // three contended attempts then success
    fail_until = rd_cnt + 3;
    cpu_wr(2'd0, 32'h0000_0005, c);
    for (int k = 0; k < 4; k++) exp_attempt(c + 6 * k, 32'h00010005);
    cpu_rd("retry_status_wr", 2'd2, 32'h1);
    idle(2);
    cpu_rd("retry_status_backoff", 2'd2, 32'h101);
    idle(16);
    cpu_rd("retry_status_done", 2'd2, 32'h302);
    cpu_rd("retry_last", 2'd3, 32'h00010005);

    // release, then run out of retries
    cpu_wr(2'd1, 32'h0, c);
    mq.push_back('{c, 1'b1, 1'b0, 32'h00010000});
    idle(1);
    fail_until = rd_cnt + 1000;
    cpu_wr(2'd0, 32'h0000_0005, c);
    for (int k = 0; k < 4; k++) exp_attempt(c + 6 * k, 32'h00010005);
    idle(20);
    cpu_rd("giveup_status", 2'd2, 32'h404);
    cpu_rd("giveup_last", 2'd3, 32'h00020007);
    idle(20);

    // ignored commands: value 0, writes while busy, acquire while held
    fail_until = rd_cnt;
    cpu_wr(2'd0, 32'hFFFF_0000, unused_c);
    cpu_rd("ign_zero_status", 2'd2, 32'h404);
    cpu_wr(2'd0, 32'h0000_0009, c);
    exp_attempt(c, 32'h00010009);
    cpu_wr(2'd0, 32'h0000_0007, unused_c);
    cpu_wr(2'd1, 32'h0, unused_c);
    cpu_rd("ign_busy_status", 2'd2, 32'h2);
    cpu_wr(2'd0, 32'h0000_0003, unused_c);
    cpu_rd("ign_held_status", 2'd2, 32'h2);
    cpu_rd("ign_last", 2'd3, 32'h00010009);
    idle(5);

    // reset pulse during backoff
    cpu_wr(2'd1, 32'h0, c);
    mq.push_back('{c, 1'b1, 1'b0, 32'h00010000});
    idle(1);
    fail_until = rd_cnt + 1000;
    cpu_wr(2'd0, 32'h0000_0005, c);
    exp_attempt(c, 32'h00010005);
    idle(3);
    s_address = 2'd2;
    #1 reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    fail_until = rd_cnt;
    idle(20);
    cpu_rd("postrst_status", 2'd2, 32'h0);
    cpu_rd("postrst_last", 2'd3, 32'h0);
    cpu_wr(2'd0, 32'h0000_0005, c);
    exp_attempt(c, 32'h00010005);
    idle(2);
    cpu_rd("postrst_acq_status", 2'd2, 32'h2);

    idle(2);
    fin = 1'b1;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
